debounce_4ch: RTL and testbench
===============================

DEBOUNCE_4CH -- requirements
Module: debounce_4ch

Upstream conditioning stage for the 4-to-2 encoder: turns four raw, asynchronous, bouncing inputs into clean one-level-per-line d_in plus press pulses.

Interface
REQ-001 SHALL have parameter CNT_MAX, default 4: consecutive clock edges a new level must persist before acceptance; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port btn_in, input, 4, raw asynchronous button/request lines, bit i = channel i.
REQ-005 SHALL have port d_out, output, 4, debounced stable level per channel; drives the encoder's d_in directly.
REQ-006 SHALL have port press, output, 4, one-cycle pulse per channel on each accepted 0->1 transition.

Function
REQ-007 SHALL pass each btn_in bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-008 SHALL keep, per channel, a counter of width ceil(log2(CNT_MAX)) bits that never exceeds CNT_MAX-1.
REQ-009 SHALL, at each edge where sync2[i] == d_out[i], load counter i with 0 and hold d_out[i].
REQ-010 SHALL, at each edge where sync2[i] != d_out[i] and counter i < CNT_MAX-1, increment counter i and hold d_out[i].
REQ-011 SHALL, at each edge where sync2[i] != d_out[i] and counter i == CNT_MAX-1, load d_out[i] with sync2[i] and counter i with 0.
REQ-012 SHALL therefore update d_out[i] on edge CNT_MAX+2, counting the first edge that samples a held btn_in change as edge 1.
REQ-013 SHALL reject any sync2 excursion shorter than CNT_MAX consecutive edges: d_out unchanged, counter returns to 0.
REQ-014 SHALL register press[i] high on the same edge that loads d_out[i] 0->1, low on every other edge; no pulse on 1->0.
REQ-015 SHALL process channels independently; simultaneous changes on several channels each complete per REQ-012 in the same cycle, and multi-bit d_out is permitted.
REQ-016 SHALL have no counter wrap: counter i reaches at most CNT_MAX-1, then returns to 0 via REQ-009 or REQ-011.

Reset
REQ-017 SHALL, while rst is high, immediately force sync1, sync2, d_out, press and all counters to 0, regardless of clk.
REQ-018 SHALL, when rst is asserted mid-count, discard the partial count; after release, a held high input needs the full CNT_MAX+2 edges again.
REQ-019 SHALL, with btn_in held high across reset release, treat the input as a new 0->1 change and produce press.

Structure
REQ-020 SHALL put per-channel logic (synchronizer, counter, level, press) in sub-module debounce_1ch, instantiated 4 times with a generate loop.
REQ-021 SHALL keep CNT_MAX as the only shared constant; it passes unchanged to debounce_1ch, and no package or typedefs are required.
REQ-022 SHALL contain no latches, no combinational path from btn_in to any output, and no second clock.

Verification (CNT_MAX=4, clk period 10, rst released before t=20)
REQ-023 SHALL cover: btn_in=0001 held from just before edge 1 -> d_out=0001 and press=0001 for exactly one cycle at edge 6; press=0000 afterwards.
REQ-024 SHALL cover: btn_in[2] high for 3 edges then low -> d_out stays 0000 and press stays 0000 throughout.
REQ-025 SHALL cover bounce 1,0,1,0 one edge each, then 1 held on bit 3 -> exactly one press[3] pulse, with d_out[3]=1 at CNT_MAX+2 edges after the final rise.
REQ-026 SHALL cover: btn_in=1111 applied at once -> d_out=1111 and press=1111 on the same edge; release to 0000 -> d_out=0000 four edges after sync2 falls, with no press.
REQ-027 SHALL cover: rst pulsed high between clk edges after 2 edges of counting on bit 1 -> outputs 0 without a clk edge; with input still high, press[1] arrives at edge 6 after release.
REQ-028 SHALL cover: d_out connected to the 4-to-2 encoder -> encoder output matches d_out and never changes during bounce.

Source files
------------

// File: rtl/debounce_4ch_pkg.sv
// rtl/debounce_4ch_pkg.sv - shared default and counter sizing for the debouncer
package debounce_4ch_pkg;

   localparam int CNT_MAX_DEFAULT = 4;

   // Width that holds 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_4ch_1ch.sv
// rtl/debounce_4ch_1ch.sv - one channel: synchronizer, persistence counter, level, press
module debounce_1ch
   import debounce_4ch_pkg::*;
#(
   parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int            W    = cnt_width(CNT_MAX);
   localparam logic [W-1:0]  LAST = W'(CNT_MAX - 1);

   logic         sync1;
   logic         sync2;
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // New level has persisted long enough; press only on a rising acceptance.
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_4ch.sv
// rtl/debounce_4ch.sv - four independent debounced channels feeding the 4-to-2 encoder
module debounce_4ch
   import debounce_4ch_pkg::*;
#(
   parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_in,
   output logic [3:0] d_out,
   output logic [3:0] press
);

   for (genvar i = 0; i < 4; i++) begin : g_ch
      debounce_1ch #(.CNT_MAX(CNT_MAX)) u_ch (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn_in[i]),
         .level (d_out[i]),
         .press (press[i])
      );
   end

endmodule

// File: tb/tb_debounce_4ch.sv
// tb/tb_debounce_4ch.sv - directed and randomized checks of debounce_4ch
module tb_debounce_4ch;

   localparam int CNT = 4;

   logic       clk;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] d_out;
   logic [3:0] press;

   int checks   = 0;
   int failures = 0;

   logic [3:0] raw_q[$];
   logic [3:0] win_q[$];
   logic [3:0] m_dout;
   logic [3:0] m_press;

   debounce_4ch #(.CNT_MAX(CNT)) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .d_out  (d_out),
      .press  (press)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] enc4to2(input logic [3:0] d);
      if (d[3]) return 2'd3;
      if (d[2]) return 2'd2;
      if (d[1]) return 2'd1;
      return 2'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      win_q.delete();
      for (int j = 0; j < CNT; j++) win_q.push_back(4'b0);
      m_dout  = 4'b0;
      m_press = 4'b0;
   endtask

   // A level is accepted once the synchronized input has disagreed with it
   // for CNT consecutive edges; synchronized input lags the pin by two edges.
   task automatic model_edge();
      logic [3:0] u;
      logic [3:0] w;
      logic       all_diff;
      raw_q.push_back(btn_in);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      u = (raw_q.size() == 3) ? raw_q[0] : 4'b0;
      win_q.push_back(u);
      if (win_q.size() > CNT) void'(win_q.pop_front());
      m_press = 4'b0;
      for (int ch = 0; ch < 4; ch++) begin
         all_diff = 1'b1;
         for (int j = 0; j < win_q.size(); j++) begin
            w = win_q[j];
            if (w[ch] == m_dout[ch]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_dout[ch]  = ~m_dout[ch];
            m_press[ch] = m_dout[ch];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("d_out_model", 32'(d_out), 32'(m_dout));
      chk("press_model", 32'(press), 32'(m_press));
      chk("encoder", 32'(enc4to2(d_out)), 32'(enc4to2(m_dout)));
   endtask

   task automatic idle(input int n);
      btn_in = 4'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int         npress;
      int         rise_edge;
      logic [3:0] seen;

      rst    = 1'b1;
      btn_in = 4'b0;
      model_reset();
      #1;
      chk("reset_d_out", 32'(d_out), 32'h0);
      chk("reset_press", 32'(press), 32'h0);
      #11;
      rst    = 1'b0;
      btn_in = 4'b0001;

      // Single channel acceptance lands on edge CNT+2.
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("single_d_out", 32'(d_out), (e == 6) ? 32'h1 : 32'h0);
         chk("single_press", 32'(press), (e == 6) ? 32'h1 : 32'h0);
      end
      tick();
      chk("single_press_after", 32'(press), 32'h0);
      idle(8);

      // Short excursion is rejected.
      seen   = 4'b0;
      btn_in = 4'b0100;
      for (int e = 0; e < 3; e++) begin tick(); seen |= d_out | press; end
      btn_in = 4'b0;
      for (int e = 0; e < 8; e++) begin tick(); seen |= d_out | press; end
      chk("glitch_quiet", 32'(seen), 32'h0);

      // Bounce then hold on channel 3.
      npress    = 0;
      rise_edge = 0;
      for (int b = 0; b < 4; b++) begin
         btn_in = (b % 2 == 0) ? 4'b1000 : 4'b0000;
         tick();
         if (press[3]) npress++;
         chk("bounce_enc_stable", 32'(enc4to2(d_out)), 32'h0);
      end
      btn_in = 4'b1000;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (press[3]) npress++;
         if (d_out[3] && rise_edge == 0) rise_edge = e;
      end
      chk("bounce_one_press", 32'(npress), 32'd1);
      chk("bounce_rise_edge", 32'(rise_edge), 32'd6);
      idle(8);

      // All channels together, then release.
      btn_in = 4'b1111;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 6) begin
            chk("all_d_out", 32'(d_out), 32'hF);
            chk("all_press", 32'(press), 32'hF);
         end
      end
      btn_in = 4'b0000;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) chk("all_hold", 32'(d_out), 32'hF);
         if (e == 6) chk("all_release", 32'(d_out), 32'h0);
         chk("all_release_press", 32'(press), 32'h0);
      end
      idle(4);

      // Asynchronous reset mid-count on channel 1 with channel 0 already high.
      btn_in = 4'b0001;
      for (int e = 0; e < 7; e++) tick();
      btn_in = 4'b0011;
      for (int e = 0; e < 4; e++) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_d_out", 32'(d_out), 32'h0);
      chk("async_rst_press", 32'(press), 32'h0);
      #1;
      rst = 1'b0;
      model_reset();
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("rst_restart_press1", 32'(press[1]), (e == 6) ? 32'h1 : 32'h0);
      end
      idle(8);

      // Randomized toggling, with one asynchronous reset in the middle.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) btn_in = btn_in ^ 4'($urandom_range(0, 15));
         tick();
         if (n == 300) begin
            #2;
            rst = 1'b1;
            #1;
            chk("rand_rst_d_out", 32'(d_out), 32'h0);
            rst = 1'b0;
            model_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
